// File: rtl/key_scanner_if.sv
// Keypad matrix and key-code FIFO signals shared by the scanner and its consumer.
// slave = scanner side, master = keypad/consumer side.
`default_nettype none
`timescale 1ns/1ps

interface key_scanner_if;
    logic [3:0] KEY_COL;
    logic [3:0] KEY_ROW;
    logic       KEY_POP;
    logic       KEY_VALID;
    logic [3:0] KEY_CODE;
    logic       KEY_OVF;

    modport slave (
        output KEY_COL,
        output KEY_VALID,
        output KEY_CODE,
        output KEY_OVF,
        input  KEY_ROW,
        input  KEY_POP
    );

    modport master (
        input  KEY_COL,
        input  KEY_VALID,
        input  KEY_CODE,
        input  KEY_OVF,
        output KEY_ROW,
        output KEY_POP
    );
endinterface

`default_nettype wire

// File: rtl/key_scanner.sv
// ============================================================================
// Module   : key_scanner
// Function : 4x4 keypad scanner with debounce FSM and 4-entry key-code FIFO.
//            Optional auto-repeat of a held key: define KEY_SCANNER_REPEAT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module key_scanner #(
    parameter int SCAN_DIV       = 1024,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 32
) (
    input  wire logic    CLK,
    input  wire logic    RST,
    key_scanner_if.slave kbd
);

    localparam int              SLOT_W      = $clog2(SCAN_DIV);
    localparam logic [SLOT_W-1:0] C_SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [3:0]      C_DEB       = 4'(DEBOUNCE_SCANS);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_PRESS_CHK = 2'd1;
    localparam logic [1:0] S_HELD      = 2'd2;
    localparam logic [1:0] S_REL_CHK   = 2'd3;

    localparam logic [1:0] R_NONE   = 2'd0;
    localparam logic [1:0] R_SINGLE = 2'd1;
    localparam logic [1:0] R_MULTI  = 2'd2;

    if ((SCAN_DIV < 2) || (DEBOUNCE_SCANS < 1) || (DEBOUNCE_SCANS > 15) ||
        (REPEAT_SCANS < 1) || (REPEAT_SCANS > 255)) begin : g_param_check
        $error("key_scanner: parameter out of range");
    end

    // ------------------------------------------------------------------
    // Row synchronizer
    // ------------------------------------------------------------------
    logic [3:0] row_meta_q;
    logic [3:0] row_sync_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= kbd.KEY_ROW;
            row_sync_q <= row_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Column slot timing
    // ------------------------------------------------------------------
    logic [SLOT_W-1:0] slot_cnt_q;
    logic [1:0]        col_idx_q;
    logic [3:0]        col_drv_q;
    logic              w_slot_last;
    logic              w_scan_done;

    assign w_slot_last = (slot_cnt_q == C_SLOT_LAST);
    assign w_scan_done = w_slot_last && (col_idx_q == 2'd3);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            slot_cnt_q <= '0;
            col_idx_q  <= 2'd0;
            col_drv_q  <= 4'b1110;
        end else if (w_slot_last) begin
            slot_cnt_q <= '0;
            col_idx_q  <= col_idx_q + 2'd1;
            col_drv_q  <= ~(4'b0001 << (col_idx_q + 2'd1));
        end else begin
            slot_cnt_q <= slot_cnt_q + SLOT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-scan classification: hit count saturates at 2 (MULTI)
    // ------------------------------------------------------------------
    logic [3:0] w_row_low;
    logic [2:0] w_slot_hits;
    logic [1:0] w_row_idx;
    logic [2:0] w_hits_sum;
    logic [1:0] w_hits_new;
    logic [3:0] w_code_new;
    logic [1:0] acc_hits_q;
    logic [3:0] acc_code_q;
    logic [1:0] w_scan_res;
    logic [3:0] w_scan_code;

    always_comb begin
        w_row_low   = ~row_sync_q;
        w_slot_hits = 3'(w_row_low[0]) + 3'(w_row_low[1]) +
                      3'(w_row_low[2]) + 3'(w_row_low[3]);
        w_row_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_row_low[i]) begin
                w_row_idx = 2'(i);
            end
        end
        w_hits_sum = {1'b0, acc_hits_q} + w_slot_hits;
        w_hits_new = (w_hits_sum >= 3'd2) ? 2'd2 : w_hits_sum[1:0];
        w_code_new = ((acc_hits_q == 2'd0) && (w_slot_hits != 3'd0)) ?
                     {w_row_idx, col_idx_q} : acc_code_q;
        w_scan_code = w_code_new;
        case (w_hits_new)
            2'd0:    w_scan_res = R_NONE;
            2'd1:    w_scan_res = R_SINGLE;
            default: w_scan_res = R_MULTI;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            acc_hits_q <= 2'd0;
            acc_code_q <= 4'd0;
        end else if (w_scan_done) begin
            acc_hits_q <= 2'd0;
            acc_code_q <= 4'd0;
        end else if (w_slot_last) begin
            acc_hits_q <= w_hits_new;
            acc_code_q <= w_code_new;
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    logic [1:0] state_q, state_d;
    logic [3:0] deb_cnt_q, deb_cnt_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] w_deb_next;
    logic       w_deb_reach;
    logic       w_same;
    logic       w_rpt_fire;
    logic       w_push;
    logic [3:0] w_push_code;

    assign w_deb_next  = deb_cnt_q + 4'd1;
    assign w_deb_reach = (w_deb_next == C_DEB);
    assign w_same      = (w_scan_res == R_SINGLE) && (w_scan_code == cand_q);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            deb_cnt_q <= 4'd0;
            cand_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            cand_q    <= cand_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        cand_d    = cand_q;
        if (w_scan_done) begin
            case (state_q)
                S_IDLE: begin
                    if (w_scan_res == R_SINGLE) begin
                        cand_d = w_scan_code;
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d   = S_HELD;
                            deb_cnt_d = 4'd0;
                        end else begin
                            state_d   = S_PRESS_CHK;
                            deb_cnt_d = 4'd1;
                        end
                    end
                end
                S_PRESS_CHK: begin
                    if (w_same && w_deb_reach) begin
                        state_d   = S_HELD;
                        deb_cnt_d = 4'd0;
                    end else if (w_same) begin
                        deb_cnt_d = w_deb_next;
                    end else begin
                        state_d   = S_IDLE;
                        deb_cnt_d = 4'd0;
                    end
                end
                S_HELD: begin
                    // A different single key is ignored until a full release.
                    if (w_scan_res == R_NONE) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d   = S_IDLE;
                            deb_cnt_d = 4'd0;
                        end else begin
                            state_d   = S_REL_CHK;
                            deb_cnt_d = 4'd1;
                        end
                    end
                end
                S_REL_CHK: begin
                    if (w_scan_res != R_NONE) begin
                        state_d   = S_HELD;
                        deb_cnt_d = 4'd0;
                    end else if (w_deb_reach) begin
                        state_d   = S_IDLE;
                        deb_cnt_d = 4'd0;
                    end else begin
                        deb_cnt_d = w_deb_next;
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    deb_cnt_d = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        w_push      = 1'b0;
        w_push_code = w_scan_code;
        if (w_scan_done) begin
            case (state_q)
                S_IDLE:      w_push = (w_scan_res == R_SINGLE) && (DEBOUNCE_SCANS == 1);
                S_PRESS_CHK: w_push = w_same && w_deb_reach;
                S_HELD:      w_push = w_rpt_fire;
                default:     w_push = 1'b0;
            endcase
        end
    end

`ifdef KEY_SCANNER_REPEAT_EN
    // Auto-repeat: consecutive same-key scans while HELD.
    logic [7:0] rpt_cnt_q, rpt_cnt_d;
    logic [7:0] w_rpt_next;

    assign w_rpt_next = rpt_cnt_q + 8'd1;
    assign w_rpt_fire = (state_q == S_HELD) && w_scan_done && w_same &&
                        (w_rpt_next == 8'(REPEAT_SCANS));

    always_comb begin
        rpt_cnt_d = rpt_cnt_q;
        if (state_q != S_HELD) begin
            rpt_cnt_d = 8'd0;
        end else if (w_scan_done) begin
            rpt_cnt_d = (w_same && !w_rpt_fire) ? w_rpt_next : 8'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            rpt_cnt_q <= 8'd0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`else
    assign w_rpt_fire = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Key-code FIFO
    // ------------------------------------------------------------------
    logic [3:0] fifo_mem_q [4];
    logic [1:0] wr_ptr_q;
    logic [1:0] rd_ptr_q;
    logic [2:0] fifo_cnt_q;
    logic       ovf_q;
    logic       w_pop_ok;
    logic       w_full;
    logic       w_push_ok;
    logic       w_drop;

    assign w_pop_ok  = kbd.KEY_POP && (fifo_cnt_q != 3'd0);
    assign w_full    = (fifo_cnt_q == 3'd4);
    assign w_push_ok = w_push && (!w_full || w_pop_ok);
    assign w_drop    = w_push && w_full && !w_pop_ok;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem_q[i] <= 4'd0;
            end
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            fifo_cnt_q <= 3'd0;
            ovf_q      <= 1'b0;
        end else begin
            // When full, a simultaneous pop frees the slot the push writes.
            if (w_push_ok) begin
                fifo_mem_q[wr_ptr_q] <= w_push_code;
                wr_ptr_q             <= wr_ptr_q + 2'd1;
            end
            if (w_pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 3'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 3'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
            if (w_drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign kbd.KEY_COL   = col_drv_q;
    assign kbd.KEY_VALID = (fifo_cnt_q != 3'd0);
    assign kbd.KEY_CODE  = (fifo_cnt_q != 3'd0) ? fifo_mem_q[rd_ptr_q] : 4'd0;
    assign kbd.KEY_OVF   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_key_scanner.sv
// Directed bench for key_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=2).
// One scan = 16 cycles; a key applied just after a scan boundary is accepted 48 cycles later.
`default_nettype none
`timescale 1ns/1ps

module tb_key_scanner;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    key_scanner_if kif();

    logic [15:0] keys = 16'd0;
    logic [3:0]  rows_low;

    // Keypad model: a pressed key pulls its row low while its column is driven.
    always_comb begin
        rows_low = 4'd0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !kif.KEY_COL[c]) begin
                    rows_low[r] = 1'b1;
                end
            end
        end
    end
    assign kif.KEY_ROW = ~rows_low;

    key_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3),
        .REPEAT_SCANS   (2)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .kbd (kif)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Returns 1ns after the edge that starts a new scan (column 3 -> column 0).
    task automatic sync_scan();
        logic [3:0] prev;
        logic       found;
        prev  = kif.KEY_COL;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(posedge CLK);
            #1;
            if (prev == 4'b0111 && kif.KEY_COL == 4'b1110) found = 1'b1;
            prev = kif.KEY_COL;
        end
        check("scan_sync", 8'(found), 8'd1);
    endtask

    task automatic pop();
        kif.KEY_POP = 1'b1;
        @(posedge CLK);
        #1;
        kif.KEY_POP = 1'b0;
    endtask

    task automatic press_release(input int code);
        sync_scan();
        keys = 16'd1 << code;
        cycles(48);
        keys = 16'd0;
        cycles(48);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        kif.KEY_POP = 1'b0;
        RST = 1'b0;
        cycles(3);
        check("rst_col",   8'(kif.KEY_COL),   8'h0E);
        check("rst_valid", 8'(kif.KEY_VALID), 8'd0);
        check("rst_code",  8'(kif.KEY_CODE),  8'd0);
        check("rst_ovf",   8'(kif.KEY_OVF),   8'd0);
        RST = 1'b1;
        cycles(2);

        // Stable press of row1/col2 -> code 6 accepted after 3 scans.
        sync_scan();
        keys = 16'd1 << 6;
        cycles(47);
        check("press_early_valid", 8'(kif.KEY_VALID), 8'd0);
        cycles(1);
        check("press_valid", 8'(kif.KEY_VALID), 8'd1);
        check("press_code",  8'(kif.KEY_CODE),  8'd6);
`ifndef KEY_SCANNER_REPEAT_EN
        cycles(80);
        check("held_valid", 8'(kif.KEY_VALID), 8'd1);
        check("held_code",  8'(kif.KEY_CODE),  8'd6);
        pop();
        check("no_repeat", 8'(kif.KEY_VALID), 8'd0);
        keys = 16'd0;
        cycles(48);
`else
        keys = 16'd0;
        pop();
        check("press_pop", 8'(kif.KEY_VALID), 8'd0);
        cycles(48);
        // Hold code 9 for 7 scans: pushes at scans 3, 5 and 7.
        sync_scan();
        keys = 16'd1 << 9;
        cycles(112);
        keys = 16'd0;
        check("rpt_code0", 8'(kif.KEY_CODE), 8'd9);
        pop();
        check("rpt_valid1", 8'(kif.KEY_VALID), 8'd1);
        check("rpt_code1",  8'(kif.KEY_CODE),  8'd9);
        pop();
        check("rpt_valid2", 8'(kif.KEY_VALID), 8'd1);
        check("rpt_code2",  8'(kif.KEY_CODE),  8'd9);
        pop();
        check("rpt_empty", 8'(kif.KEY_VALID), 8'd0);
        cycles(48);
`endif
        check("release_empty", 8'(kif.KEY_VALID), 8'd0);

        // Bouncing code 5: pressed/released alternating for 5 scans, then stable.
        sync_scan();
        for (int i = 0; i < 5; i++) begin
            keys = (i % 2 == 0) ? (16'd1 << 5) : 16'd0;
            cycles(16);
        end
        check("bounce_valid0", 8'(kif.KEY_VALID), 8'd0);
        keys = 16'd1 << 5;
        cycles(16);
        check("bounce_valid1", 8'(kif.KEY_VALID), 8'd0);
        cycles(16);
        check("bounce_valid2", 8'(kif.KEY_VALID), 8'd1);
        check("bounce_code",   8'(kif.KEY_CODE),  8'd5);
        keys = 16'd0;
        pop();
        check("bounce_single", 8'(kif.KEY_VALID), 8'd0);
        cycles(48);

        // Two keys at once -> MULTI, never accepted.
        sync_scan();
        keys = (16'd1 << 1) | (16'd1 << 2);
        cycles(80);
        check("multi_valid", 8'(kif.KEY_VALID), 8'd0);
        keys = 16'd0;
        cycles(16);

        // Five accepted presses without popping: 5th is dropped, overflow set.
        for (int k = 1; k <= 5; k++) press_release(k);
        check("ovf_valid", 8'(kif.KEY_VALID), 8'd1);
        check("ovf_head",  8'(kif.KEY_CODE),  8'd1);
        check("ovf_flag",  8'(kif.KEY_OVF),   8'd1);

        // Pop coincident with the push of code 7 while full.
        sync_scan();
        keys = 16'd1 << 7;
        cycles(47);
        kif.KEY_POP = 1'b1;
        cycles(1);
        kif.KEY_POP = 1'b0;
        keys = 16'd0;
        check("pp_valid", 8'(kif.KEY_VALID), 8'd1);
        check("pp_head",  8'(kif.KEY_CODE),  8'd2);
        check("pp_ovf",   8'(kif.KEY_OVF),   8'd1);
        pop();
        check("pp_code3", 8'(kif.KEY_CODE), 8'd3);
        pop();
        check("pp_code4", 8'(kif.KEY_CODE), 8'd4);
        pop();
        check("pp_code7", 8'(kif.KEY_CODE), 8'd7);
        pop();
        check("pp_empty", 8'(kif.KEY_VALID), 8'd0);
        pop();
        check("pop_empty_ignored", 8'(kif.KEY_VALID), 8'd0);
        cycles(48);

        // Reset during PRESS_CHK with two entries queued.
        press_release(3);
        press_release(4);
        check("q2_head", 8'(kif.KEY_CODE), 8'd3);
        sync_scan();
        keys = 16'd1 << 6;
        cycles(20);
        RST = 1'b0;
        cycles(1);
        RST = 1'b1;
        check("mid_rst_col",   8'(kif.KEY_COL),   8'h0E);
        check("mid_rst_valid", 8'(kif.KEY_VALID), 8'd0);
        check("mid_rst_code",  8'(kif.KEY_CODE),  8'd0);
        check("mid_rst_ovf",   8'(kif.KEY_OVF),   8'd0);
        cycles(47);
        check("redeb_early", 8'(kif.KEY_VALID), 8'd0);
        cycles(1);
        check("redeb_valid", 8'(kif.KEY_VALID), 8'd1);
        check("redeb_code",  8'(kif.KEY_CODE),  8'd6);
        keys = 16'd0;
        pop();
        cycles(48);
        check("final_empty", 8'(kif.KEY_VALID), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/key_scanner.md
KEY_SCANNER -- requirements
Module: key_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1024: clock cycles per column slot (minimum 2).
REQ-002 Parameter DEBOUNCE_SCANS, default 4: consecutive identical full scans needed to accept a press or a release (range 1-15).
REQ-003 Parameter REPEAT_SCANS, default 32: full scans between auto-repeat codes while a key is held (range 1-255).
REQ-004 Port CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 Port RST  input  1  reset, synchronous, active-low.
REQ-006 Port KEY_COL  output  4  column drive, active-low one-hot.
REQ-007 Port KEY_ROW  input  4  row sense, active-low (pulled up externally), asynchronous to CLK.
REQ-008 Port KEY_POP  input  1  consumer dequeues head entry when high and KEY_VALID high.
REQ-009 Port KEY_VALID  output  1  FIFO non-empty.
REQ-010 Port KEY_CODE  output  4  head entry code, row*4+col; 0 when empty.
REQ-011 Port KEY_OVF  output  1  sticky overflow flag.

Function
REQ-012 KEY_ROW SHALL pass through a 2-flop synchronizer before any use.
REQ-013 Column index SHALL advance 0,1,2,3,0... every SCAN_DIV cycles; KEY_COL = ~(1<<index), registered.
REQ-014 Rows SHALL be sampled only on the last cycle of each slot; one full scan = 4 slots = 4*SCAN_DIV cycles.
REQ-015 Per full scan, result SHALL be NONE (no row low), SINGLE(code) (exactly one asserted row/column pair), or MULTI (two or more).
REQ-016 Debounce FSM states: IDLE, PRESS_CHK, HELD, REL_CHK.
REQ-017 IDLE: SINGLE(c) -> PRESS_CHK with candidate c, count 1; else stay.
REQ-018 PRESS_CHK: SINGLE(c) same candidate increments count; when count reaches DEBOUNCE_SCANS, push c and -> HELD; any other result -> IDLE. With DEBOUNCE_SCANS=1, SINGLE in IDLE pushes directly and enters HELD.
REQ-019 HELD: NONE -> REL_CHK, count 1; SINGLE(same) or MULTI stays HELD; SINGLE(different) stays HELD (no push; new key needs release first).
REQ-020 REL_CHK: NONE increments count; at DEBOUNCE_SCANS -> IDLE; any non-NONE result -> HELD.
REQ-021 FIFO: 4 entries x 4 bits; KEY_VALID and KEY_CODE reflect head combinationally from registers; push visible on KEY_VALID the cycle after the final accepting sample.
REQ-022 Pop with FIFO empty SHALL be ignored.
REQ-023 Push while full and no pop SHALL drop the new code and set KEY_OVF; KEY_OVF clears only on reset.
REQ-024 Push and pop in the same cycle SHALL both take effect, including when full (count unchanged, no overflow).
REQ-025 Pointers SHALL wrap modulo 4; occupancy held in a 3-bit counter 0-4.

Reset
REQ-026 With RST low at a rising edge: column index 0, KEY_COL=4'b1110, slot counter 0, FSM IDLE, debounce count 0, FIFO empty, KEY_VALID=0, KEY_CODE=0, KEY_OVF=0, synchronizer flops all 1.
REQ-027 Reset mid-scan or mid-debounce SHALL discard all partial state; a held key SHALL be re-debounced from IDLE after reset release.

Configuration
REQ-028 Macro KEY_SCANNER_REPEAT_EN defined: in HELD, a scan counter counts consecutive SINGLE(same) scans; at REPEAT_SCANS it pushes the held code again and restarts; any other result resets the counter.
REQ-029 Macro undefined: no repeat counter exists; exactly one push per accepted press.

Verification
REQ-030 SCAN_DIV=4, DEBOUNCE_SCANS=3: hold row1/col2 stable -> exactly one push, KEY_CODE=6, KEY_VALID high within 3 full scans (48 cycles) plus synchronizer latency, no further push while held (macro off).
REQ-031 Row bouncing low/high every scan for 5 scans then stable low -> no push until 3 stable scans; exactly one code.
REQ-032 Press code 1 and code 2 simultaneously -> MULTI, no push; KEY_VALID stays 0.
REQ-033 Five debounced press/release cycles for codes 1,2,3,4,5, no pops -> FIFO holds 1,2,3,4 in order, KEY_OVF=1; then pop+push same cycle when full -> count 4, KEY_OVF unchanged.
REQ-034 RST low for one cycle during PRESS_CHK with two entries queued -> all outputs at reset values next cycle, KEY_COL=4'b1110.
REQ-035 KEY_SCANNER_REPEAT_EN defined, REPEAT_SCANS=2: hold code 9 for 3+4 scans -> pushes 9 at acceptance then every 2 scans (3 entries total after 7 scans).
